// File: rtl/class_argmax_reader.sv
// Pops IEEE-754 score words from the accelerator output FIFO and reports the per-image argmax.
// Latency: one word per 2 cycles (pop, then compare); result_valid pulses the cycle after the final compare.
// Backpressure: pops only while the FIFO is non-empty, one pop in flight; stops popping once NUM_IMG images are done.
module class_argmax_reader #(
    parameter int NUM_CLASS = 10,
    parameter int NUM_IMG   = 1,
    parameter int IDX_W     = 10
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [31:0]      fifo_data,
    input  logic             fifo_last,
    input  logic             fifo_empty,
    output logic             fifo_rdreq,
    output logic [IDX_W-1:0] class_idx,
    output logic [31:0]      class_score,
    output logic             result_valid,
    output logic [15:0]      img_count,
    output logic             frame_err,
    output logic             done
);

    localparam int              CNT_W      = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(NUM_CLASS - 1);
    localparam logic [15:0]     IMG_TARGET = 16'(NUM_IMG);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] word_cnt;
    logic [31:0]      max_score;
    logic [CNT_W-1:0] max_idx;

    logic             word_nan;
    logic             take;
    logic             at_last_cnt;
    logic             img_end;
    logic             frame_bad;
    logic [15:0]      img_count_inc;
    logic             all_done;
    logic [IDX_W-1:0] win_idx;
    logic [31:0]      win_score;

    // Order-preserving map from float bits to an unsigned key: negatives reversed, positives above them.
    function automatic logic [31:0] score_key(input logic [31:0] w);
        return w[31] ? ~w : {1'b1, w[30:0]};
    endfunction

    assign word_nan      = (fifo_data[30:23] == 8'hFF) && (fifo_data[22:0] != 23'd0);
    assign take          = (word_cnt == '0) ||
                           (!word_nan && (score_key(fifo_data) > score_key(max_score)));
    assign at_last_cnt   = (word_cnt == LAST_CNT);
    assign img_end       = fifo_last || at_last_cnt;
    assign frame_bad     = fifo_last ^ at_last_cnt;
    assign img_count_inc = (img_count == 16'hFFFF) ? img_count : img_count + 16'd1;
    assign all_done      = (img_count_inc >= IMG_TARGET);
    assign win_idx       = IDX_W'(take ? word_cnt : max_idx);
    assign win_score     = take ? fifo_data : max_score;

    always_comb begin
        state_nxt  = state;
        fifo_rdreq = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !done) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                fifo_rdreq = !fifo_empty;
                if (!fifo_empty) begin
                    state_nxt = CMP;
                end
            end
            CMP: begin
                state_nxt = (img_end && all_done) ? DONE : READ;
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            word_cnt     <= '0;
            max_score    <= 32'd0;
            max_idx      <= '0;
            class_idx    <= '0;
            class_score  <= 32'd0;
            result_valid <= 1'b0;
            img_count    <= 16'd0;
            frame_err    <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            result_valid <= 1'b0;
            if (state == CMP) begin
                if (take) begin
                    max_score <= fifo_data;
                    max_idx   <= word_cnt;
                end
                if (img_end) begin
                    word_cnt     <= '0;
                    class_idx    <= win_idx;
                    class_score  <= win_score;
                    result_valid <= 1'b1;
                    img_count    <= img_count_inc;
                    if (frame_bad) begin
                        frame_err <= 1'b1;
                    end
                    if (all_done) begin
                        done <= 1'b1;
                    end
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_class_argmax_reader.sv
// Directed bench for class_argmax_reader: FIFO model with optional random empty gaps, float-level argmax model.
module tb_class_argmax_reader;

    localparam int NUM_CLASS = 4;
    localparam int NUM_IMG   = 2;
    localparam int IDX_W     = 10;

    logic             clk = 1'b0;
    logic             resetn;
    logic [31:0]      fifo_data;
    logic             fifo_last;
    logic             fifo_empty;
    logic             fifo_rdreq;
    logic [IDX_W-1:0] class_idx;
    logic [31:0]      class_score;
    logic             result_valid;
    logic [15:0]      img_count;
    logic             frame_err;
    logic             done;

    class_argmax_reader #(.NUM_CLASS(NUM_CLASS), .NUM_IMG(NUM_IMG), .IDX_W(IDX_W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .fifo_data    (fifo_data),
        .fifo_last    (fifo_last),
        .fifo_empty   (fifo_empty),
        .fifo_rdreq   (fifo_rdreq),
        .class_idx    (class_idx),
        .class_score  (class_score),
        .result_valid (result_valid),
        .img_count    (img_count),
        .frame_err    (frame_err),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] score;
        bit          err;
    } res_t;

    int          n_checks = 0;
    int          n_errs   = 0;
    logic [32:0] q[$];
    res_t        exp_q[$];
    bit          will_pop  = 1'b0;
    bit          rand_gate = 1'b0;

    int          m_cnt    = 0;
    logic [31:0] m_best_w = 32'd0;
    int          m_best_i = 0;
    int          cnt_exp  = 0;
    bit          err_exp  = 1'b0;
    int          last_idx = 0;
    logic [31:0] last_score = 32'd0;
    logic [31:0] pool [0:7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic real f2r(input logic [31:0] w);
        int  e;
        real m;
        real v;
        e = int'(w[30:23]);
        m = real'(w[22:0]) / 8388608.0;
        if (e == 0) v = m * (2.0 ** -126.0);
        else        v = (1.0 + m) * (2.0 ** real'(e - 127));
        return w[31] ? -v : v;
    endfunction

    function automatic bit is_nan(input logic [31:0] w);
        return (w[30:23] == 8'hFF) && (w[22:0] != 23'd0);
    endfunction

    // Numeric comparison on real values; +0.0 is treated as above -0.0.
    function automatic bit beats(input logic [31:0] w, input logic [31:0] best);
        real rw;
        real rb;
        if (is_nan(w)) return 1'b0;
        rw = f2r(w);
        rb = f2r(best);
        if (rw > rb) return 1'b1;
        if (rw == rb && rw == 0.0 && best[31] && !w[31]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push_word(input logic [31:0] w, input bit last);
        res_t r;
        q.push_back({last, w});
        if (m_cnt == 0 || beats(w, m_best_w)) begin
            m_best_w = w;
            m_best_i = m_cnt;
        end
        m_cnt++;
        if (last || m_cnt == NUM_CLASS) begin
            r.idx   = m_best_i;
            r.score = m_best_w;
            r.err   = (last != (m_cnt == NUM_CLASS));
            exp_q.push_back(r);
            m_cnt = 0;
        end
    endtask

    task automatic push4(input logic [31:0] a, b, c, d, input int last_at);
        push_word(a, last_at == 0);
        push_word(b, last_at == 1);
        push_word(c, last_at == 2);
        push_word(d, last_at == 3);
    endtask

    // Reset lands mid-cycle so its effect on the outputs is visibly asynchronous.
    task automatic do_reset();
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        q.delete();
        exp_q.delete();
        will_pop   = 1'b0;
        rand_gate  = 1'b0;
        m_cnt      = 0;
        cnt_exp    = 0;
        err_exp    = 1'b0;
        last_idx   = 0;
        last_score = 32'd0;
        chk("rst_class_idx", 32'(class_idx), 32'd0);
        chk("rst_class_score", class_score, 32'd0);
        chk("rst_img_count", 32'(img_count), 32'd0);
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rdreq", 32'(fifo_rdreq), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic wait_rv(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            #3;
            seen = result_valid;
        end
        if (!seen) begin
            n_checks++;
            n_errs++;
            $display("FAIL %s: result_valid timeout, got none expected pulse", name);
        end
    endtask

    task automatic wait_result(input string name, input int idx, input logic [31:0] score);
        wait_rv(name);
        chk({name, "_idx"}, 32'(class_idx), 32'(idx));
        chk({name, "_score"}, class_score, score);
    endtask

    // FIFO model: data appears the cycle after a sampled pop; otherwise the bus carries junk.
    always @(negedge clk) begin
        if (will_pop) begin
            if (q.size() > 0) begin
                {fifo_last, fifo_data} = q.pop_front();
            end else begin
                n_checks++;
                n_errs++;
                $display("FAIL fifo_underflow: got pop expected none");
            end
        end else begin
            fifo_data = 32'hDEAD_BEEF;
            fifo_last = 1'b1;
        end
        fifo_empty = (q.size() == 0) || (rand_gate && ($urandom_range(0, 2) == 0));
        #2;
        will_pop = fifo_rdreq && resetn;
    end

    // Per-cycle comparison against the model's view of completed images.
    always @(negedge clk) begin
        res_t e;
        #1;
        if (result_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL spurious_result: got result_valid=1 expected 0");
            end else begin
                e          = exp_q.pop_front();
                last_idx   = e.idx;
                last_score = e.score;
                err_exp    = err_exp | e.err;
                cnt_exp    = (cnt_exp == 65535) ? cnt_exp : cnt_exp + 1;
            end
        end
        chk("mon_class_idx", 32'(class_idx), 32'(last_idx));
        chk("mon_class_score", class_score, last_score);
        chk("mon_img_count", 32'(img_count), 32'(cnt_exp));
        chk("mon_frame_err", 32'(frame_err), 32'(err_exp));
        chk("mon_done", 32'(done), 32'(cnt_exp >= NUM_IMG));
        chk("mon_rdreq_while_empty", 32'(fifo_rdreq & fifo_empty), 32'd0);
        if (cnt_exp >= NUM_IMG) chk("mon_rdreq_after_done", 32'(fifo_rdreq), 32'd0);
    end

    initial begin
        resetn     = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = 32'd0;
        fifo_last  = 1'b0;
        pool[0] = 32'h3F80_0000;  // 1.0
        pool[1] = 32'h4060_0000;  // 3.5
        pool[2] = 32'hC000_0000;  // -2.0
        pool[3] = 32'h0000_0000;  // +0.0
        pool[4] = 32'h8000_0000;  // -0.0
        pool[5] = 32'h3F00_0000;  // 0.5
        pool[6] = 32'hBF00_0000;  // -0.5
        pool[7] = 32'h4060_0000;  // 3.5 again, for ties

        // Basic image with a tie, then all-negative image reaching done.
        do_reset();
        push4(32'h3F80_0000, 32'h4060_0000, 32'hC000_0000, 32'h4060_0000, 3);
        wait_result("tie_keeps_low", 1, 32'h4060_0000);
        chk("tie_img_count", 32'(img_count), 32'd1);
        chk("tie_frame_err", 32'(frame_err), 32'd0);
        @(negedge clk);
        #3;
        chk("rv_single_pulse", 32'(result_valid), 32'd0);
        push4(32'hC0A0_0000, 32'hBF00_0000, 32'hBF80_0000, 32'h8000_0000, 3);
        wait_result("all_negative", 3, 32'h8000_0000);
        chk("done_after_two", 32'(done), 32'd1);
        push4(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 3);
        repeat (20) @(negedge clk);
        chk("no_pop_after_done", 32'(q.size()), 32'd4);

        // +0.0 over -0.0, and NaN skipped.
        do_reset();
        push4(32'h8000_0000, 32'h0000_0000, 32'hBF80_0000, 32'h8000_0000, 3);
        wait_result("pos_zero_wins", 1, 32'h0000_0000);
        push4(32'h3F00_0000, 32'h3E80_0000, 32'h7FC0_0000, 32'h3F40_0000, 3);
        wait_result("nan_skipped", 3, 32'h3F40_0000);

        // Early last flag closes the image and flags a frame error.
        do_reset();
        push_word(32'h3F80_0000, 1'b0);
        push_word(32'h4000_0000, 1'b0);
        push_word(32'h4040_0000, 1'b1);
        wait_result("early_last", 2, 32'h4040_0000);
        chk("early_last_err", 32'(frame_err), 32'd1);
        push4(32'h4080_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 3);
        wait_result("next_img_idx0", 0, 32'h4080_0000);
        chk("err_sticky", 32'(frame_err), 32'd1);

        // Reset in the middle of an image after one completed image.
        do_reset();
        push4(32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 3);
        wait_result("pre_reset_img", 0, 32'h4000_0000);
        push_word(32'h3F80_0000, 1'b0);
        push_word(32'h4000_0000, 1'b0);
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        do_reset();
        push4(32'h3F00_0000, 32'h4080_0000, 32'hBF80_0000, 32'h4040_0000, 3);
        wait_result("post_reset_img", 1, 32'h4080_0000);
        chk("post_reset_count", 32'(img_count), 32'd1);

        // Random FIFO gaps; second image lacks its last flag.
        do_reset();
        rand_gate = 1'b1;
        for (int w = 0; w < 4; w++) push_word(pool[$urandom_range(0, 7)], w == 3);
        for (int w = 0; w < 4; w++) push_word(pool[$urandom_range(0, 7)], 1'b0);
        wait_rv("rand_img0");
        wait_rv("rand_img1");
        chk("rand_done", 32'(done), 32'd1);
        chk("rand_missing_last_err", 32'(frame_err), 32'd1);
        push_word(32'h3F80_0000, 1'b1);
        repeat (20) @(negedge clk);
        chk("rand_no_pop_after_done", 32'(q.size()), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/class_argmax_reader.md
CLASS_ARGMAX_READER -- requirements
Module: class_argmax_reader

Interface
REQ-001 The block SHALL have parameter NUM_CLASS, default 10, meaning score words per image (1..1024).
REQ-002 The block SHALL have parameter NUM_IMG, default 1, meaning images to process before done (1..65535).
REQ-003 The block SHALL have parameter IDX_W, default 10, meaning width of class index output (>= clog2(NUM_CLASS)).
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all logic on rising edge.
REQ-005 The block SHALL have port resetn, input, 1, meaning asynchronous active-low reset.
REQ-006 The block SHALL have port fifo_data, input, 32, meaning the IEEE-754 single-precision score word from the accelerator output FIFO.
REQ-007 The block SHALL have port fifo_last, input, 1, meaning the FIFO's image_class flag; high marks the last score word of an image.
REQ-008 The block SHALL have port fifo_empty, input, 1, meaning the output FIFO holds no word.
REQ-009 The block SHALL have port fifo_rdreq, output, 1, meaning pop request; data is valid on the cycle after rdreq is sampled high.
REQ-010 The block SHALL have port class_idx, output, IDX_W, meaning the winning class index of the last image.
REQ-011 The block SHALL have port class_score, output, 32, meaning the winning score word, unmodified.
REQ-012 The block SHALL have port result_valid, output, 1, meaning a one-cycle pulse when class_idx/class_score update.
REQ-013 The block SHALL have port img_count, output, 16, meaning completed images.
REQ-014 The block SHALL have port frame_err, output, 1, meaning sticky flag for a word-count/last-flag mismatch.
REQ-015 The block SHALL have port done, output, 1, meaning sticky high once img_count reaches NUM_IMG.

Function
REQ-016 The FSM SHALL have states IDLE, READ, CMP, DONE; reset enters IDLE.
REQ-017 IDLE SHALL go to READ on the first cycle fifo_empty is low and done is low.
REQ-018 In READ, fifo_rdreq SHALL equal !fifo_empty; at most one pop is outstanding, and the next cycle is CMP only if a pop was issued.
REQ-019 In CMP, the word captured one cycle after the pop SHALL be compared, and the state SHALL return to READ the same cycle, giving a sustained rate of one word per 2 cycles.
REQ-020 Compare SHALL map each word to a key: sign=1 inverts all 32 bits, sign=0 flips bit 31; comparison is unsigned on keys, so +0 > -0.
REQ-021 The first word of an image (word counter = 0) SHALL always load the running max; later words replace it only on strictly greater key, so ties keep the lower index.
REQ-022 Words with exponent 0xFF and nonzero mantissa (NaN) SHALL never replace the running max, except as the first word.
REQ-023 The word counter SHALL increment per compared word and clear at image end.
REQ-024 An image SHALL end on the CMP of a word with fifo_last=1, or when the counter reaches NUM_CLASS-1, whichever comes first.
REQ-025 At image end, class_idx and class_score SHALL load the final max (including the current word), result_valid SHALL pulse for the next cycle, and img_count SHALL increment.
REQ-026 frame_err SHALL set if fifo_last=1 arrives with counter != NUM_CLASS-1, or if the counter reaches NUM_CLASS-1 with fifo_last=0; the image still completes per REQ-024.
REQ-027 When img_count reaches NUM_IMG, the FSM SHALL enter DONE, set done, and hold fifo_rdreq low until reset.
REQ-028 fifo_rdreq SHALL never be high while fifo_empty is high.
REQ-029 img_count SHALL saturate at 16'hFFFF.

Reset
REQ-030 Asserting resetn low at any time, including mid-image, SHALL asynchronously clear the FSM to IDLE and clear fifo_rdreq, result_valid, done, frame_err, class_idx, class_score, img_count, the word counter and the running max, all to 0.
REQ-031 After resetn deasserts, no pop SHALL occur before the first rising edge at which resetn is high.

Verification
REQ-032 NUM_CLASS=4, scores {1.0, 3.5, -2.0, 3.5}, last on word 3 -> class_idx=1, class_score=0x40600000, one result_valid pulse, img_count=1, frame_err=0.
REQ-033 All-negative scores {-5.0, -0.5, -1.0, -0.0}, NUM_CLASS=4 -> class_idx=3 (-0.0 is the max); then +0.0 versus -0.0 in another image -> +0.0 wins.
REQ-034 NUM_CLASS=4, last asserted on word 2 -> image closes after 3 words, frame_err=1, next image starts at index 0.
REQ-035 fifo_empty toggled randomly across 2 images, NUM_IMG=2 -> no rdreq while empty, results match a model, done=1 after the second result_valid, and rdreq stays 0 afterward.
REQ-036 resetn pulsed low after word 2 of an image -> all outputs are 0 immediately; the following full image yields a correct result, with img_count=1.
REQ-037 A NaN (0x7FC00000) in word 2 of {0.5, 0.25, NaN, 0.75} -> class_idx=3.
